mem_port_arbiter: RTL

Two-requester arbiter that shares the single unified instruction/data memory port. Requester 0 is the multicycle core's fetch/load/store path; requester 1 is the boot loader / debug port.
Round-robin grant, with request attributes latched at grant and a req/ready handshake to memory. A watchdog aborts accesses that memory never completes and returns an error response.

---
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals shared by the two-port
// memory arbiter and whatever surrounds it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // Handshake: a requester raises reqN with its attributes and holds them
  // until the one-cycle doneN pulse. The memory sees mem_req with stable
  // mem_* fields until it answers with a one-cycle mem_ready (mem_rdata
  // valid in that cycle). mem_ready outside an issued access is ignored.
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [STRB_W-1:0] wstrb0;
  logic [STRB_W-1:0] wstrb1;
  logic              done0;
  logic              done1;
  logic              err0;
  logic              err1;
  logic [DATA_W-1:0] rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter view.
  modport master (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1,
    output done0, done1, err0, err1, rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    output busy
  );

  // Requester / memory view.
  modport slave (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1,
    input  done0, done1, err0, err1, rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core (port 0) and
// the boot/debug port (port 1), with a watchdog that aborts stuck accesses.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus,
  output logic [1:0]          state_dbg
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int CNT_W     = $clog2(TIMEOUT) + 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam bit   WD_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              last_gnt_q;
  logic              gnt_id_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [STRB_W-1:0] mem_wstrb_q;
  logic [DATA_W-1:0] rdata_q;

  logic              grant_valid;
  logic              grant_id;
  logic              issue_ok;
  logic              issue_to;
  logic              wd_fire;
  logic              done0_w;
  logic              done1_w;

  assign wd_fire = WD_EN && (cnt_q == TO_LAST);

  // Next-state and grant decode. A tie goes to the port that did not win last.
  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    issue_ok    = 1'b0;
    issue_to    = 1'b0;
    case (state_q)
      IDLE: begin
        grant_valid = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) grant_id = ~last_gnt_q;
        else                      grant_id = bus.req1;
        if (grant_valid) state_d = ISSUE;
      end
      ISSUE: begin
        // mem_ready wins over a watchdog expiry in the same cycle.
        if (bus.mem_ready) begin
          issue_ok = 1'b1;
          state_d  = RESP;
        end else if (wd_fire) begin
          issue_to = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_id_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_valid) begin
        gnt_id_q   <= grant_id;
        last_gnt_q <= grant_id;
      end
    end
  end

  // Attributes are captured once at grant so requesters may change their
  // inputs while the access is in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else if (grant_valid) begin
      mem_we_q    <= grant_id ? bus.we1    : bus.we0;
      mem_addr_q  <= grant_id ? bus.addr1  : bus.addr0;
      mem_wdata_q <= grant_id ? bus.wdata1 : bus.wdata0;
      mem_wstrb_q <= grant_id ? bus.wstrb1 : bus.wstrb0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (grant_valid) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      if (issue_ok) begin
        err_q <= 1'b0;
        if (!mem_we_q) rdata_q <= bus.mem_rdata;
      end else if (issue_to) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign done0_w       = (state_q == RESP) && !gnt_id_q;
  assign done1_w       = (state_q == RESP) &&  gnt_id_q;

  assign bus.done0     = done0_w;
  assign bus.done1     = done1_w;
  assign bus.err0      = done0_w && err_q;
  assign bus.err1      = done1_w && err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = (state_q == ISSUE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.busy      = (state_q != IDLE);
  assign state_dbg     = state_q;

  a_done_onehot: assert property (@(posedge clk) !(done0_w && done1_w));

  a_issue_stable: assert property (@(posedge clk)
    (rst && state_q == ISSUE && state_d == ISSUE) |=>
      ($stable(mem_addr_q) && $stable(mem_wdata_q) &&
       $stable(mem_wstrb_q) && $stable(mem_we_q)));

  a_resp_one_cycle: assert property (@(posedge clk)
    (rst && state_q == RESP) |=> (state_q == IDLE));

endmodule
